// File: rtl/mac_ctrl_pkg.sv
// Shared encodings for the systolic MAC array sequencer: FSM states, array
// instruction codes and dataflow mode values.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GAP   = 3'd2,
    S_EXEC  = 3'd3,
    S_DRAIN = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Command/L0/array-edge bundle between the MAC sequencer (slave) and its user.
// stall_cnt exists only when MAC_CTRL_PERF_EN is defined.
interface mac_array_ctrl_if #(parameter int VEC_BW = 8);
  logic              start;
  logic              mode;
  logic [VEC_BW-1:0] num_vec;
  logic              l0_empty;
  logic              l0_rd;
  logic [1:0]        inst_w;
  logic              mode_select;
  logic              output_en;
  logic              out_valid;
  logic              busy;
  logic              done;
`ifdef MAC_CTRL_PERF_EN
  logic [15:0]       stall_cnt;
`endif

  modport master (
    output start, mode, num_vec, l0_empty,
    input  l0_rd, inst_w, mode_select, output_en, out_valid, busy, done
`ifdef MAC_CTRL_PERF_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, mode, num_vec, l0_empty,
    output l0_rd, inst_w, mode_select, output_en, out_valid, busy, done
`ifdef MAC_CTRL_PERF_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/mac_ctrl_cnt.sv
// Loadable down-counter with enable and zero flag; load wins over enable.
module mac_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= val;
    else if (en)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for the ROW x COL systolic MAC array (WS and OS dataflows).
// Optional MAC_CTRL_PERF_EN adds a saturating L0 stall counter.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int VEC_BW = 8
) (
  input logic             clk,
  input logic             reset,
  mac_array_ctrl_if.slave bus
);
  localparam int WW = (VEC_BW > $clog2(COL + 1)) ? VEC_BW : $clog2(COL + 1);
  localparam int DW = $clog2(ROW + COL + 1);

  state_t state, state_nx;

  logic              accept, l0_rd, feeding;
  logic [VEC_BW-1:0] vec_q;
  logic              mode_q, busy_q, done_q, oen_q, ovld_q;
  logic [1:0]        inst_q;

  logic          work_ld, work_en, work_zero;
  logic [WW-1:0] work_val;
  logic          wait_ld, wait_en, wait_zero;
  logic [DW-1:0] wait_val;

  // busy_q also covers the done cycle, so a start there is still ignored
  assign accept  = (state == S_IDLE) && bus.start && !busy_q;
  assign feeding = (state == S_LOAD) || (state == S_EXEC);
  assign l0_rd   = feeding && !bus.l0_empty;

  // Counters hold N-1 so the phase ends on the cycle the last beat is issued
  mac_ctrl_cnt #(.W(WW)) u_work (
    .clk(clk), .reset(reset), .load(work_ld), .en(work_en),
    .val(work_val), .zero(work_zero)
  );

  mac_ctrl_cnt #(.W(DW)) u_wait (
    .clk(clk), .reset(reset), .load(wait_ld), .en(wait_en),
    .val(wait_val), .zero(wait_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    work_ld  = 1'b0;
    work_val = '0;
    wait_ld  = 1'b0;
    wait_val = '0;
    work_en  = l0_rd && !work_zero;
    wait_en  = ((state == S_GAP) || (state == S_DRAIN) || (state == S_SHIFT)) && !wait_zero;
    case (state)
      S_IDLE: if (accept) begin
        if (bus.num_vec == '0) begin
          state_nx = S_DONE;
        end else if (bus.mode == MODE_OS) begin
          state_nx = S_EXEC;
          work_ld  = 1'b1;
          work_val = WW'(bus.num_vec) - 1'b1;
        end else begin
          state_nx = S_LOAD;
          work_ld  = 1'b1;
          work_val = WW'(COL - 1);
        end
      end
      S_LOAD: if (l0_rd && work_zero) begin
        state_nx = S_GAP;
        wait_ld  = 1'b1;
        wait_val = DW'(COL - 1);
      end
      S_GAP: if (wait_zero) begin
        state_nx = S_EXEC;
        work_ld  = 1'b1;
        work_val = WW'(vec_q) - 1'b1;
      end
      S_EXEC: if (l0_rd && work_zero) begin
        state_nx = S_DRAIN;
        wait_ld  = 1'b1;
        wait_val = DW'(ROW + COL - 1);
      end
      S_DRAIN: if (wait_zero) begin
        if (mode_q == MODE_OS) begin
          state_nx = S_SHIFT;
          wait_ld  = 1'b1;
          wait_val = DW'(ROW - 1);
        end else begin
          state_nx = S_DONE;
        end
      end
      S_SHIFT: if (wait_zero) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Array-facing outputs trail the FSM by one register to match L0 read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q  <= '0;
      mode_q <= MODE_WS;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      inst_q <= INST_IDLE;
      oen_q  <= 1'b0;
      ovld_q <= 1'b0;
    end else begin
      if (accept) begin
        vec_q  <= bus.num_vec;
        mode_q <= bus.mode;
      end
      busy_q <= (state != S_IDLE) || accept;
      done_q <= (state == S_DONE);
      if (l0_rd)                 inst_q <= (state == S_LOAD) ? INST_LOAD : INST_EXEC;
      else if (state == S_SHIFT) inst_q <= INST_EXEC;
      else                       inst_q <= INST_IDLE;
      oen_q  <= (state == S_SHIFT);
      ovld_q <= (state == S_SHIFT);
    end
  end

  assign bus.l0_rd       = l0_rd;
  assign bus.inst_w      = inst_q;
  assign bus.mode_select = mode_q;
  assign bus.output_en   = oen_q;
  assign bus.out_valid   = ovld_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

`ifdef MAC_CTRL_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset)                                          stall_q <= '0;
    else if (accept)                                    stall_q <= '0;
    else if (feeding && bus.l0_empty && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
  end

  assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl (ROW=COL=8): WS/OS timelines, L0 stalls,
// zero-length ops, ignored starts and mid-operation reset.
module tb_mac_array_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  int   cyc;

  always #5 clk = ~clk;

  mac_array_ctrl_if #(.VEC_BW(8)) bus();
  mac_array_ctrl #(.ROW(8), .COL(8), .VEC_BW(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] o;
  assign o = {bus.inst_w, bus.l0_rd, bus.busy, bus.done, bus.output_en, bus.out_valid, bus.mode_select};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  function automatic logic [7:0] pack(logic [1:0] iw, logic rd, logic bsy, logic dn,
                                      logic oen, logic ov, logic ms);
    return {iw, rd, bsy, dn, oen, ov, ms};
  endfunction

  // WS timeline, start sampled at cycle 0, no stalls
  function automatic logic [7:0] exp_ws(int k, int nv);
    logic [1:0] iw;
    iw = (k >= 2 && k <= 9) ? 2'b01 : (k >= 18 && k <= 17 + nv) ? 2'b10 : 2'b00;
    return pack(iw, (k >= 1 && k <= 8) || (k >= 17 && k <= 16 + nv),
                k >= 1 && k <= 34 + nv, k == 34 + nv, 1'b0, 1'b0, 1'b0);
  endfunction

  // OS timeline: nv exec, 16 drain, 8 shift-out, done
  function automatic logic [7:0] exp_os(int k, int nv);
    logic sh;
    logic [1:0] iw;
    sh = (k >= nv + 18 && k <= nv + 25);
    iw = ((k >= 2 && k <= nv + 1) || sh) ? 2'b10 : 2'b00;
    return pack(iw, k >= 1 && k <= nv, k >= 1 && k <= nv + 26, k == nv + 26, sh, sh, 1'b1);
  endfunction

  initial begin
    int n_ld, n_ex, n_rd, n_hole, done_at;
    bus.start = 1'b0; bus.mode = 1'b0; bus.num_vec = '0; bus.l0_empty = 1'b0;
    cyc = 0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    chk("reset_outs", 32'(o), 32'h0);
`ifdef MAC_CTRL_PERF_EN
    chk("reset_stall", 32'(bus.stall_cnt), 32'h0);
`endif

    // WS nv=4; starts at cycle 5 (busy) and 38 (done cycle) must be ignored
    bus.mode = 1'b0; bus.num_vec = 8'd4; bus.start = 1'b1; cyc = 0;
    for (int k = 1; k <= 42; k++) begin
      tick();
      chk($sformatf("ws4_c%0d", k), 32'(o), 32'(exp_ws(k, 4)));
      bus.start = (k == 5) || (k == 38);
      bus.mode  = (k == 5);
    end
    bus.start = 1'b0; bus.mode = 1'b0;

    // OS nv=3
    bus.mode = 1'b1; bus.num_vec = 8'd3; bus.start = 1'b1; cyc = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("os3_c%0d", k), 32'(o), 32'(exp_os(k, 3)));
      bus.start = 1'b0;
    end

    // num_vec=0: no reads, done two cycles after start
    bus.mode = 1'b0; bus.num_vec = 8'd0; bus.start = 1'b1; cyc = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("zero_c%0d", k), 32'(o),
          32'(pack(2'b00, 1'b0, k <= 2, k == 2, 1'b0, 1'b0, 1'b0)));
      bus.start = 1'b0;
    end

    // WS nv=4 with L0 empty for cycles 18..22 of EXEC
    bus.num_vec = 8'd4; bus.start = 1'b1; cyc = 0;
    n_ld = 0; n_ex = 0; n_rd = 0; n_hole = 0; done_at = -1;
    for (int k = 1; k <= 46; k++) begin
      tick();
      if (bus.inst_w == 2'b01) n_ld++;
      if (bus.inst_w == 2'b10) n_ex++;
      if (bus.l0_rd) n_rd++;
      if (k >= 19 && k <= 23 && bus.inst_w == 2'b00) n_hole++;
      if (bus.done && done_at < 0) done_at = k;
      bus.start = 1'b0;
      bus.l0_empty = (k >= 18 && k <= 22);
    end
    chk("stall_load_cycles", 32'(n_ld), 32'd8);
    chk("stall_exec_cycles", 32'(n_ex), 32'd4);
    chk("stall_reads", 32'(n_rd), 32'd12);
    chk("stall_idle_holes", 32'(n_hole), 32'd5);
    chk("stall_done_cycle", 32'(done_at), 32'd43);
    chk("stall_busy_after", 32'(bus.busy), 32'd0);
`ifdef MAC_CTRL_PERF_EN
    chk("stall_cnt", 32'(bus.stall_cnt), 32'd5);
`endif

    // reset mid-EXEC, then a fresh OS op
    bus.mode = 1'b0; bus.num_vec = 8'd4; bus.start = 1'b1; cyc = 0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      bus.start = 1'b0;
    end
    chk("pre_rst_exec", 32'(o), 32'(exp_ws(19, 4)));
    reset = 1'b1;
    tick();
    chk("rst_mid_outs", 32'(o), 32'h0);
    reset = 1'b0;
    tick();
    bus.mode = 1'b1; bus.num_vec = 8'd2; bus.start = 1'b1; cyc = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("os2_c%0d", k), 32'(o), 32'(exp_os(k, 2)));
      bus.start = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
